// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the accumulator CPU control unit:
//   - datapath word width
//   - opcode constants for the 4-bit opcode field IR[15:12]
//   - SKIPCOND condition codes carried in IR[11:10]
//   - the sequencer state enumeration
//   - a helper that picks the state following a completed instruction
// Build option: CPU_CTRL_INDIRECT_EN adds the pointer-chase states used by
// ADDI/JUMPI. Without it those states do not exist.
package cpu_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUBT     = 4'h4;
  localparam logic [3:0] OP_HALT     = 4'h7;
  localparam logic [3:0] OP_SKIPCOND = 4'h8;
  localparam logic [3:0] OP_JUMP     = 4'h9;
  localparam logic [3:0] OP_CLEAR    = 4'hA;
  localparam logic [3:0] OP_ADDI     = 4'hB;
  localparam logic [3:0] OP_JUMPI    = 4'hC;

  localparam logic [1:0] SKIP_NEG   = 2'b00;
  localparam logic [1:0] SKIP_ZERO  = 2'b01;
  localparam logic [1:0] SKIP_POS   = 2'b10;
  localparam logic [1:0] SKIP_NEVER = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH_A = 4'd1,
    S_FETCH_R = 4'd2,
    S_FETCH_L = 4'd3,
    S_DECODE  = 4'd4,
    S_OPER_R  = 4'd5,
    S_OPER_L  = 4'd6,
    S_STORE_W = 4'd7,
    S_HALTED  = 4'd8
`ifdef CPU_CTRL_INDIRECT_EN
    ,
    S_PTR_R   = 4'd9,
    S_PTR_L   = 4'd10
`endif
  } state_t;

  // An instruction boundary is the only place run is looked at.
  function automatic state_t boundary_state(input logic run);
    return run ? S_FETCH_A : S_IDLE;
  endfunction

endpackage

// File: rtl/cpu_control_unit_acc_alu.sv
// acc_alu
// Combinational accumulator arithmetic for the control unit.
//   a       : accumulator value (also the operand of the sign/zero tests)
//   b       : memory operand
//   sub     : 1 selects a-b, 0 selects a+b (both modulo 2^DATA_W)
//   result  : arithmetic result
//   is_neg  : a < 0 as a two's-complement value
//   is_zero : a == 0
//   is_pos  : a > 0 as a two's-complement value
module acc_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              is_neg,
  output logic              is_zero,
  output logic              is_pos
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] res_s;

  assign a_s   = a;
  assign b_s   = b;
  // Carry/borrow out is dropped: the ISA has no flags.
  assign res_s = sub ? (a_s - b_s) : (a_s + b_s);
  assign result = res_s;

  assign is_neg  = a_s[DATA_W-1];
  assign is_zero = (a == '0);
  assign is_pos  = !is_neg && !is_zero;

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// Fetch/decode/execute sequencer for the 16-bit accumulator CPU. Acts as
// initiator on a main-memory port whose read data is registered (valid the
// cycle after the address is presented). Holds PC, AC, IR, MAR and MBR and
// runs one instruction at a time.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   run       : level enable, sampled only at instruction boundaries
//   mem_addr  : zero-extended MAR
//   mem_wdata : MBR
//   mem_we    : write strobe, high only in STORE_W
//   mem_rdata : registered memory read data
//   halted    : high while in HALTED
//   pc, ac, ir: architectural registers
//
// Build option: define CPU_CTRL_INDIRECT_EN to enable ADDI (0xB) and JUMPI
// (0xC) with the PTR_R/PTR_L states; otherwise both opcodes are NOPs.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] ir
);

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] x_addr;
  logic [1:0]        cond;
  logic [ADDR_W-1:0] pc_inc;

  logic [DATA_W-1:0] alu_result;
  logic              ac_neg;
  logic              ac_zero;
  logic              ac_pos;
  logic              skip_taken;

  assign opcode = ir[15:12];
  assign x_addr = ir[ADDR_W-1:0];
  assign cond   = ir[11:10];
  assign pc_inc = pc + 1'b1;

  acc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a       (ac),
    .b       (mem_rdata),
    .sub     (opcode == OP_SUBT),
    .result  (alu_result),
    .is_neg  (ac_neg),
    .is_zero (ac_zero),
    .is_pos  (ac_pos)
  );

  always_comb begin
    skip_taken = 1'b0;
    case (cond)
      SKIP_NEG:   skip_taken = ac_neg;
      SKIP_ZERO:  skip_taken = ac_zero;
      SKIP_POS:   skip_taken = ac_pos;
      SKIP_NEVER: skip_taken = 1'b0;
      default:    skip_taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_addr[ADDR_W-1:0] = mar;
  end

  assign mem_wdata = mbr;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs; mem_we follows state directly so
  // an asynchronous reset drops it before the next edge.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = S_FETCH_A;
        end
      end
      S_FETCH_A: state_nxt = S_FETCH_R;
      S_FETCH_R: state_nxt = S_FETCH_L;
      S_FETCH_L: state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT: state_nxt = S_OPER_R;
          OP_STORE:                 state_nxt = S_STORE_W;
          OP_HALT:                  state_nxt = S_HALTED;
`ifdef CPU_CTRL_INDIRECT_EN
          OP_ADDI:                  state_nxt = S_PTR_R;
          OP_JUMPI:                 state_nxt = S_OPER_R;
`endif
          default:                  state_nxt = boundary_state(run);
        endcase
      end
      S_OPER_R: state_nxt = S_OPER_L;
      S_OPER_L: state_nxt = boundary_state(run);
      S_STORE_W: begin
        mem_we    = 1'b1;
        state_nxt = boundary_state(run);
      end
`ifdef CPU_CTRL_INDIRECT_EN
      S_PTR_R: state_nxt = S_PTR_L;
      S_PTR_L: state_nxt = S_OPER_R;
`endif
      S_HALTED: begin
        halted    = 1'b1;
        state_nxt = S_HALTED;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Architectural and memory-interface registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= RESET_PC;
      ac  <= '0;
      ir  <= '0;
      mar <= '0;
      mbr <= '0;
    end else begin
      case (state)
        S_FETCH_A: begin
          mar <= pc;
        end
        S_FETCH_L: begin
          ir <= mem_rdata;
          pc <= pc_inc;
        end
        S_DECODE: begin
          // MBR is loaded for every instruction; only STORE consumes it.
          mar <= x_addr;
          mbr <= ac;
          case (opcode)
            OP_JUMP:  pc <= x_addr;
            OP_CLEAR: ac <= '0;
            OP_SKIPCOND: begin
              if (skip_taken) begin
                pc <= pc_inc;
              end
            end
            default: ;
          endcase
        end
        S_OPER_L: begin
          case (opcode)
            OP_LOAD:          ac <= mem_rdata;
            OP_ADD, OP_SUBT:  ac <= alu_result;
`ifdef CPU_CTRL_INDIRECT_EN
            OP_ADDI:          ac <= alu_result;
            OP_JUMPI:         pc <= mem_rdata[ADDR_W-1:0];
`endif
            default: ;
          endcase
        end
`ifdef CPU_CTRL_INDIRECT_EN
        S_PTR_L: begin
          // Second hop of ADDI: the fetched word becomes the operand address.
          mar <= mem_rdata[ADDR_W-1:0];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Fetch/decode/execute sequencer for the 16-bit accumulator CPU. It is the initiator on the main-memory port: it drives address, write data and write enable, and consumes the memory's registered read data, which has one-cycle latency. It holds PC, AC, IR, MAR and MBR internally and executes a 4-bit-opcode, 12-bit-address accumulator ISA, one instruction at a time.

## Interface
Parameters:
- ADDR_W, 12, operand/PC width; instruction address field is IR[ADDR_W-1:0]
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level enable; sampled only at instruction boundaries
- mem_addr  out  16  zero-extended MAR
- mem_wdata  out  16  MBR
- mem_we  out  1  memory write strobe
- mem_rdata  in  16  memory read data, valid the cycle after the address is presented with mem_we=0
- halted  out  1  high while in HALTED
- pc  out  ADDR_W  program counter
- ac  out  16  accumulator
- ir  out  16  instruction register

## Operation
- Encoding: opcode = IR[15:12], X = IR[ADDR_W-1:0].
- 0x1 LOAD: AC←M[X]
- 0x2 STORE: M[X]←AC
- 0x3 ADD: AC←AC+M[X]
- 0x4 SUBT: AC←AC−M[X]
- 0x7 HALT
- 0x8 SKIPCOND: IR[11:10] selects the test. 00 tests AC<0 (signed), 01 tests AC==0, 10 tests AC>0, 11 never skips. On a true test, PC←PC+1.
- 0x9 JUMP: PC←X
- 0xA CLEAR: AC←0
- 0xB ADDI: AC←AC+M[M[X]]; 0xC JUMPI: PC←M[X]. Both only when the indirect feature is compiled in (see Configuration).
- All other opcodes execute as NOP.
- Arithmetic is modulo 2^16. No flags.
- PC increment wraps from 2^ADDR_W−1 to 0.
- State machine:
  - IDLE: go to FETCH_A when run=1.
  - FETCH_A: MAR←PC.
  - FETCH_R: memory read.
  - FETCH_L: IR←mem_rdata, PC←PC+1.
  - DECODE: MAR←X, MBR←AC. Single-cycle ops (JUMP, CLEAR, SKIPCOND, NOP) complete here. HALT goes to HALTED.
  - OPER_R: memory read.
  - OPER_L: for LOAD/ADD/SUBT, AC updated from mem_rdata. For JUMPI, PC←mem_rdata[ADDR_W-1:0].
  - STORE_W: mem_we=1.
  - PTR_R: memory read (ADDI pointer).
  - PTR_L: MAR←mem_rdata[ADDR_W-1:0], then go to OPER_R.
  - HALTED: terminal; exited only by reset.
- Completion of any instruction goes to FETCH_A if run=1, else IDLE.
- mem_we is decoded combinationally from state and is high only in STORE_W.

## Timing
- Reset values: state IDLE, pc=RESET_PC, ac=0, ir=0, MAR=0, MBR=0, mem_addr=0, mem_wdata=0, mem_we=0, halted=0.
- Cycles per instruction, from entering FETCH_A to the last execute state:
  - JUMP, CLEAR, SKIPCOND, NOP, HALT: 4
  - STORE: 5
  - LOAD, ADD, SUBT, JUMPI: 6
  - ADDI: 8
- Read protocol: mem_addr is held stable with mem_we=0 during an *_R state. mem_rdata is captured only in the following *_L state.
- Write protocol: mem_we is high for exactly one cycle. mem_addr and mem_wdata are stable for that whole cycle.
- run deasserting mid-instruction does not stop the current instruction; the controller stops at the next boundary.
- Reset mid-instruction: all registers clear immediately. mem_we falls asynchronously, so no memory write occurs at the next edge.
- halted rises in the first HALTED cycle and stays high.

## Configuration
- CPU_CTRL_INDIRECT_EN defined: ADDI and JUMPI decode as specified, and the PTR_R/PTR_L states exist.
- Not defined: opcodes 0xB and 0xC are 4-cycle NOPs, and PTR_R/PTR_L are not compiled.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode constants
  - SKIPCOND condition codes
  - the state enumeration
- Sub-module acc_alu: combinational add/sub and the sign/zero tests used for AC updates and SKIPCOND.
- Registers and the FSM stay in cpu_control_unit.

## Test plan
- Program M[0]=0x1004, M[1]=0x3005, M[2]=0x2006, M[3]=0x7000, M[4]=0x0007, M[5]=0x0003; run=1.
  - Expect M[6]=0x000A, ac=0x000A, pc=0x004, halted=1.
  - mem_we is high exactly once, with mem_addr=0x0006 and mem_wdata=0x000A.
- CLEAR (0xA000), then SKIPCOND 0x8400 at address 1.
  - Expect the instruction at address 2 to be skipped; pc=3 after the skip.
  - With ac=0x0001, the same SKIPCOND does not skip.
- LOAD 0x0001, then SUBT of a word holding 0x0002.
  - Expect ac=0xFFFF. A following SKIPCOND 0x8000 skips; SKIPCOND 0x8800 does not.
- JUMP 0x9FFF with NOP at 0xFFF: expect pc=0xFFF, then pc=0x000 after the NOP, which fetches M[0].
- Assert reset during STORE_W:
  - mem_we falls in the same cycle and the target word is unchanged.
  - pc=RESET_PC, ac=0, state IDLE.
  - With run=0 after reset, no memory access occurs.
- ADDI 0xB008 with M[8]=0x0009, M[9]=0x0005, ac=2:
  - Macro on: ac=0x0007 after 8 cycles.
  - Macro off: ac stays 2 and the instruction takes 4 cycles.
